icache_responder: RTL and testbench

//  Direct-mapped instruction cache: the responder for the fetch stage's PC lookups.

---
 rtl/icache_pkg.sv | 23 ++
 rtl/icache_refill_fsm.sv | 63 ++++++
 rtl/icache_responder.sv | 127 ++++++++++++
 tb/tb_icache_responder.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared FSM encoding, NOP constant and address-split width helpers
package icache_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_FILL = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic int off_width(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int idx_width(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_width(input int addr_w, input int lines, input int words_per_line);
        return addr_w - $clog2(lines) - $clog2(words_per_line) - 2;
    endfunction

endpackage

// File: rtl/icache_refill_fsm.sv
// rtl/icache_refill_fsm.sv - refill sequencer: state, beat counter, drop flag, request handshake
module icache_refill_fsm
    import icache_pkg::*;
#(
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_W         = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [ADDR_W-1:0]                     start_addr,
    input  logic                                  flush,
    input  logic                                  mem_req_ready,
    input  logic                                  mem_rsp_valid,
    output logic [1:0]                            state,
    output logic [off_width(WORDS_PER_LINE)-1:0]  beat,
    output logic                                  drop,
    output logic                                  mem_req_valid,
    output logic [ADDR_W-1:0]                     mem_req_addr
);

    localparam int OFF_W = off_width(WORDS_PER_LINE);

    assign mem_req_valid = (state == ST_REQ);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            beat         <= '0;
            drop         <= 1'b0;
            mem_req_addr <= '0;
        end else begin
            // A flush during an active refill only poisons the line; the bus sequence still completes.
            drop <= (state != ST_IDLE) && (drop || flush);
            case (state)
                ST_IDLE: begin
                    beat <= '0;
                    if (start) begin
                        mem_req_addr <= start_addr;
                        state        <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        state <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (mem_rsp_valid) begin
                        beat <= beat + OFF_W'(1);
                        if (&beat) begin
                            state <= ST_DONE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/icache_responder.sv
// rtl/icache_responder.sv - direct-mapped I-cache lookup and arrays; ICACHE_STATS_EN adds hit/miss counters
module icache_responder
    import icache_pkg::*;
#(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_pc,
    input  logic              flush,
    output logic [31:0]       instr,
    output logic              hit,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rsp_data
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int OFF_W    = off_width(WORDS_PER_LINE);
    localparam int IDX_W    = idx_width(LINES);
    localparam int TAG_W    = tag_width(ADDR_W, LINES, WORDS_PER_LINE);
    localparam int LINE_LSB = OFF_W + 2;

    logic [OFF_W-1:0]  off;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] line_base;
    logic              pc_unused;

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tag_ram  [LINES];
    logic [31:0]       data_ram [LINES*WORDS_PER_LINE];

    logic [1:0]        state;
    logic [OFF_W-1:0]  beat;
    logic              drop;
    logic              miss;
    logic              beat_we;
    logic              last_beat;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;

    assign off       = fetch_pc[LINE_LSB-1:2];
    assign idx       = fetch_pc[LINE_LSB +: IDX_W];
    assign tag       = fetch_pc[ADDR_W-1 -: TAG_W];
    assign line_base = {fetch_pc[ADDR_W-1:LINE_LSB], {LINE_LSB{1'b0}}};
    assign pc_unused = ^fetch_pc[1:0];

    // The refill target is taken from the latched request address, so a PC redirect mid-refill is harmless.
    assign fill_idx  = mem_req_addr[LINE_LSB +: IDX_W];
    assign fill_tag  = mem_req_addr[ADDR_W-1 -: TAG_W];

    assign hit       = fetch_req && (state == ST_IDLE) && !flush && valid[idx] && (tag_ram[idx] == tag);
    assign miss      = fetch_req && (state == ST_IDLE) && !flush && !hit;
    assign instr     = hit ? data_ram[{idx, off}] : NOP_INSTR;
    assign beat_we   = (state == ST_FILL) && mem_rsp_valid;
    assign last_beat = beat_we && (&beat);

    icache_refill_fsm #(
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .ADDR_W         (ADDR_W)
    ) u_refill_fsm (
        .clk            (clk),
        .rst            (rst),
        .start          (miss),
        .start_addr     (line_base),
        .flush          (flush),
        .mem_req_ready  (mem_req_ready),
        .mem_rsp_valid  (mem_rsp_valid),
        .state          (state),
        .beat           (beat),
        .drop           (drop),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr)
    );

    // Flush wins over validation, so a flush coinciding with the last beat leaves the line invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else begin
            if (miss) begin
                valid[idx] <= 1'b0;
            end
            if (last_beat && !drop) begin
                valid[fill_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (beat_we) begin
            data_ram[{fill_idx, beat}] <= mem_rsp_data;
        end
        if (last_beat) begin
            tag_ram[fill_idx] <= fill_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (miss) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_responder.sv
// tb/tb_icache_responder.sv - randomized self-checking bench with a line-level cache model
module tb_icache_responder;

    localparam int LINES  = 16;
    localparam int WPL    = 4;
    localparam int ADDR_W = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, fetch_req, flush, hit;
    logic        mem_req_valid, mem_req_ready, mem_rsp_valid;
    logic [31:0] fetch_pc, instr, mem_req_addr, mem_rsp_data;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    bit          m_valid [LINES];
    logic [31:0] m_tag   [LINES];
    int          exp_hits, exp_misses;

    int          ready_delay = 0;
    bit          gap_en = 1'b0;
    bit          noise_en = 1'b0;
    logic [31:0] exp_base = '0;
    int          handshakes = 0;
    int          req_cycles = 0;
    int          wait_cnt = 0;
    int          fill_beat = 0;
    bit          pending = 1'b0;
    logic [31:0] fill_base = '0;

    always #5 clk = ~clk;

    icache_responder #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WPL),
        .ADDR_W         (ADDR_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_req      (fetch_req),
        .fetch_pc       (fetch_pc),
        .flush          (flush),
        .instr          (instr),
        .hit            (hit),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt        (hit_cnt),
        .miss_cnt       (miss_cnt)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:4] == 28'h10) return 32'hA + {30'b0, a[3:2]};
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    function automatic int line_of(input logic [31:0] pc);
        return int'((pc / (WPL * 4)) % LINES);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc / (WPL * 4 * LINES);
    endfunction

    function automatic bit model_hit(input logic [31:0] pc);
        return m_valid[line_of(pc)] && (m_tag[line_of(pc)] == tag_of(pc));
    endfunction

    task automatic model_fill(input logic [31:0] pc);
        m_valid[line_of(pc)] = 1'b1;
        m_tag[line_of(pc)]   = tag_of(pc);
    endtask

    task automatic model_flush();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    endtask

    // Backing memory: accepts requests after ready_delay wait cycles and streams a line of beats.
    always @(posedge clk) begin
        if (rst) begin
            pending  = 1'b0;
            wait_cnt = 0;
        end else if (mem_req_valid && mem_req_ready) begin
            pending   = 1'b1;
            fill_base = mem_req_addr;
            fill_beat = 0;
            handshakes++;
        end else if (pending && mem_rsp_valid) begin
            fill_beat++;
            if (fill_beat == WPL) pending = 1'b0;
        end
        #1;
        if (mem_req_valid) begin
            req_cycles++;
            n_cmp++;
            if (mem_req_addr !== exp_base) begin
                n_fail++;
                $display("FAIL req_addr: got %h expected %h", mem_req_addr, exp_base);
            end
            mem_req_ready = (wait_cnt >= ready_delay);
            wait_cnt++;
        end else begin
            mem_req_ready = 1'b0;
            wait_cnt      = 0;
        end
        if (pending) begin
            mem_rsp_valid = !(gap_en && ($urandom_range(0, 2) == 0));
            mem_rsp_data  = mem_word(fill_base + 32'(fill_beat) * 4);
        end else begin
            mem_rsp_valid = noise_en && ($urandom_range(0, 1) == 1);
            mem_rsp_data  = $urandom;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [31:0] pc, input string name, input int exp_lat);
        bit          exp_hit;
        int          hs0;
        int          cyc;
        exp_hit    = model_hit(pc);
        exp_base   = pc & ~32'(WPL * 4 - 1);
        hs0        = handshakes;
        req_cycles = 0;
        fetch_req  = 1'b1;
        fetch_pc   = pc;
        @(negedge clk);
        n_cmp++;
        if (hit !== exp_hit) begin
            n_fail++;
            $display("FAIL %s first_hit pc=%h: got %b expected %b", name, pc, hit, exp_hit);
        end
        if (!exp_hit) begin
            cyc = 0;
            while (hit !== 1'b1 && cyc < 300) begin
                step();
                @(negedge clk);
                cyc++;
            end
            n_cmp++;
            if (hit !== 1'b1) begin
                n_fail++;
                $display("FAIL %s refill_timeout pc=%h: got hit=%b expected 1", name, pc, hit);
            end
            if (exp_lat > 0) begin
                n_cmp++;
                if (cyc != exp_lat) begin
                    n_fail++;
                    $display("FAIL %s latency pc=%h: got %0d expected %0d", name, pc, cyc, exp_lat);
                end
            end
            n_cmp++;
            if (handshakes - hs0 != 1) begin
                n_fail++;
                $display("FAIL %s req_count pc=%h: got %0d expected 1", name, pc, handshakes - hs0);
            end
            n_cmp++;
            if (req_cycles != ready_delay + 1) begin
                n_fail++;
                $display("FAIL %s req_cycles pc=%h: got %0d expected %0d", name, pc, req_cycles, ready_delay + 1);
            end
            model_fill(pc);
            exp_misses++;
        end else begin
            n_cmp++;
            if (handshakes != hs0) begin
                n_fail++;
                $display("FAIL %s spurious_req pc=%h: got %0d expected 0", name, pc, handshakes - hs0);
            end
        end
        n_cmp++;
        if (instr !== mem_word(pc)) begin
            n_fail++;
            $display("FAIL %s instr pc=%h: got %h expected %h", name, pc, instr, mem_word(pc));
        end
        exp_hits++;
        step();
        fetch_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; fetch_req = 1'b0; fetch_pc = '0; flush = 1'b0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        model_flush();
        exp_hits = 0; exp_misses = 0;
        repeat (3) step();
        rst = 1'b0;
        fetch_req = 1'b1; fetch_pc = 32'h100;
        @(negedge clk);
        n_cmp++;
        if (hit !== 1'b0 || instr !== NOP) begin
            n_fail++;
            $display("FAIL reset_lookup: got hit=%b instr=%h expected hit=0 instr=%h", hit, instr, NOP);
        end
        n_cmp++;
        if (mem_req_valid !== 1'b0 || mem_req_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_req: got valid=%b addr=%h expected 0/0", mem_req_valid, mem_req_addr);
        end
`ifdef ICACHE_STATS_EN
        n_cmp++;
        if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_stats: got %0d/%0d expected 0/0", hit_cnt, miss_cnt);
        end
`endif
        fetch_req = 1'b0;
        step();
    endtask

    task automatic test_cold_warm_conflict();
        do_fetch(32'h100, "cold", 7);
        do_fetch(32'h104, "warm", 0);
        do_fetch(32'h108, "warm", 0);
        do_fetch(32'h10C, "warm", 0);
        noise_en = 1'b1;
        do_fetch(32'h200, "conflict", 7);
        do_fetch(32'h100, "conflict", 7);
        noise_en = 1'b0;
    endtask

    task automatic test_backpressure();
        ready_delay = 5;
        do_fetch(32'h204, "backpressure", 12);
        ready_delay = 0;
    endtask

    task automatic test_flush();
        int hs0;
        int cyc;
        flush = 1'b1; step(); flush = 1'b0;
        model_flush();
        hs0 = handshakes; exp_base = 32'h100;
        fetch_req = 1'b1; fetch_pc = 32'h100;
        cyc = 0;
        while (!(pending && fill_beat == 2) && cyc < 50) begin step(); cyc++; end
        flush = 1'b1; step(); flush = 1'b0;
        @(negedge clk);
        cyc = 0;
        while (hit !== 1'b1 && cyc < 100) begin step(); @(negedge clk); cyc++; end
        n_cmp++;
        if (handshakes - hs0 != 2) begin
            n_fail++;
            $display("FAIL flush_fill req_count: got %0d expected 2", handshakes - hs0);
        end
        n_cmp++;
        if (hit !== 1'b1 || instr !== 32'hA) begin
            n_fail++;
            $display("FAIL flush_fill refetch: got hit=%b instr=%h expected 1/%h", hit, instr, 32'hA);
        end
        model_fill(32'h100);
        exp_misses += 2; exp_hits++;
        step(); fetch_req = 1'b0;

        do_fetch(32'h300, "flush_idle_prep", 7);
        do_fetch(32'h104, "flush_idle_prep", 0);
        hs0 = handshakes;
        fetch_req = 1'b1; fetch_pc = 32'h104; flush = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (hit !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle hit: got %b expected 0", hit);
        end
        step(); flush = 1'b0; fetch_req = 1'b0;
        model_flush();
        @(negedge clk);
        n_cmp++;
        if (mem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle no_refill: got %b expected 0", mem_req_valid);
        end
        step();
        do_fetch(32'h104, "after_flush", 7);
        do_fetch(32'h300, "after_flush", 7);
    endtask

    task automatic test_random();
        logic [31:0] bases [6];
        logic [31:0] pc;
        bases = '{32'h100, 32'h200, 32'h310, 32'h1000, 32'h2340, 32'h5550};
        noise_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            ready_delay = $urandom_range(0, 3);
            gap_en      = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 9) == 0) begin
                flush = 1'b1; step(); flush = 1'b0;
                model_flush();
            end
            pc = bases[$urandom_range(0, 5)] + 32'($urandom_range(0, WPL - 1)) * 4;
            do_fetch(pc, "random", 0);
        end
        ready_delay = 0; gap_en = 1'b0; noise_en = 1'b0;
`ifdef ICACHE_STATS_EN
        n_cmp++;
        if (hit_cnt !== 32'(exp_hits) || miss_cnt !== 32'(exp_misses)) begin
            n_fail++;
            $display("FAIL stats: got %0d/%0d expected %0d/%0d", hit_cnt, miss_cnt, exp_hits, exp_misses);
        end
`endif
    endtask

    task automatic test_reset_in_fill();
        int cyc;
        exp_base = 32'h400;
        fetch_req = 1'b1; fetch_pc = 32'h400;
        cyc = 0;
        while (!(pending && fill_beat == 1) && cyc < 50) begin step(); cyc++; end
        rst = 1'b1; step(); rst = 1'b0; fetch_req = 1'b0;
        model_flush();
        exp_hits = 0; exp_misses = 0;
        @(negedge clk);
        n_cmp++;
        if (mem_req_valid !== 1'b0 || hit !== 1'b0 || instr !== NOP) begin
            n_fail++;
            $display("FAIL rst_in_fill: got valid=%b hit=%b instr=%h expected 0/0/%h", mem_req_valid, hit, instr, NOP);
        end
`ifdef ICACHE_STATS_EN
        n_cmp++;
        if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_in_fill stats: got %0d/%0d expected 0/0", hit_cnt, miss_cnt);
        end
`endif
        step();
        do_fetch(32'h400, "after_rst", 7);
    endtask

    initial begin
        test_reset();
        test_cold_warm_conflict();
        test_backpressure();
        test_flush();
        test_random();
        test_reset_in_fill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
